// File: rtl/bit_count_unit.sv
// Purpose: counts zeros, ones, leading zeros or trailing zeros of {i_argA, i_argB}, CHUNK bits per cycle.
// Latency: o_valid pulses in the cycle after edge t+NCH when i_start is sampled at edge t (NCH = 2*BITS/CHUNK).
// Backpressure: none; i_start is ignored while busy and honoured in IDLE or DONE (back-to-back every NCH+1 cycles).
module bit_count_unit #(
    parameter int BITS  = 8,
    parameter int CHUNK = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [1:0]      i_mode,
    input  logic [BITS-1:0] i_argA,
    input  logic [BITS-1:0] i_argB,
    output logic            o_busy,
    output logic            o_valid,
    output logic [BITS-1:0] o_result
);

    localparam int WW  = 2 * BITS;
    localparam int NCH = WW / CHUNK;
    localparam int AW  = $clog2(WW) + 1;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    localparam logic [1:0] MODE_ZEROS = 2'b00;
    localparam logic [1:0] MODE_ONES  = 2'b01;
    localparam logic [1:0] MODE_LZ    = 2'b10;
    localparam logic [1:0] MODE_TZ    = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WW-1:0]    word;
    logic [1:0]       mode;
    logic [AW-1:0]    acc;
    logic             found;
    logic [IW-1:0]    idx;

    logic [CHUNK-1:0] slice;
    logic [AW-1:0]    ones_cnt;
    logic [AW-1:0]    lz_cnt;
    logic [AW-1:0]    tz_cnt;
    logic [AW-1:0]    add_val;
    logic [AW-1:0]    acc_next;
    logic             found_next;
    logic             lz_hit;
    logic             tz_hit;

    // Slice evaluation: the operand is kept in a shift register so the current
    // slice always sits at the top (MSB-first modes) or bottom (trailing-zero mode).
    always_comb begin
        slice      = (mode == MODE_TZ) ? word[CHUNK-1:0] : word[WW-1 -: CHUNK];
        ones_cnt   = '0;
        lz_cnt     = '0;
        tz_cnt     = '0;
        lz_hit     = 1'b0;
        tz_hit     = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (slice[i]) begin
                ones_cnt = ones_cnt + AW'(1);
            end
        end
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (slice[i]) begin
                lz_hit = 1'b1;
            end else if (!lz_hit) begin
                lz_cnt = lz_cnt + AW'(1);
            end
        end
        for (int i = 0; i < CHUNK; i++) begin
            if (slice[i]) begin
                tz_hit = 1'b1;
            end else if (!tz_hit) begin
                tz_cnt = tz_cnt + AW'(1);
            end
        end
        add_val    = '0;
        found_next = found;
        case (mode)
            MODE_ZEROS: add_val = AW'(CHUNK) - ones_cnt;
            MODE_ONES:  add_val = ones_cnt;
            MODE_LZ: begin
                add_val    = found ? '0 : lz_cnt;
                found_next = found | (|slice);
            end
            default: begin
                add_val    = found ? '0 : tz_cnt;
                found_next = found | (|slice);
            end
        endcase
        acc_next = acc + add_val;
    end

    // Control FSM with registered outputs; a new start is accepted from IDLE or DONE only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            word     <= '0;
            mode     <= MODE_ZEROS;
            acc      <= '0;
            found    <= 1'b0;
            idx      <= '0;
            o_busy   <= 1'b0;
            o_valid  <= 1'b0;
            o_result <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        word   <= {i_argA, i_argB};
                        mode   <= i_mode;
                        acc    <= '0;
                        found  <= 1'b0;
                        idx    <= '0;
                        state  <= RUN;
                        o_busy <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                RUN: begin
                    word  <= (mode == MODE_TZ) ? (word >> CHUNK) : (word << CHUNK);
                    acc   <= acc_next;
                    found <= found_next;
                    idx   <= idx + IW'(1);
                    if (idx == LAST_IDX) begin
                        state    <= DONE;
                        o_busy   <= 1'b0;
                        o_valid  <= 1'b1;
                        o_result <= BITS'(acc_next);
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_count_unit.sv
// Purpose: self-checking bench for bit_count_unit with directed and random counts against a word-level model.
// Latency: expects o_valid one cycle after edge t+4 for a start at edge t (BITS=8, CHUNK=4).
// Backpressure: exercises start-while-busy, reset abort and back-to-back starts.
module tb_bit_count_unit;

    localparam int BITS  = 8;
    localparam int CHUNK = 4;
    localparam int WW    = 2 * BITS;

    logic            i_clk;
    logic            i_rst;
    logic            i_start;
    logic [1:0]      i_mode;
    logic [BITS-1:0] i_argA;
    logic [BITS-1:0] i_argB;
    logic            o_busy;
    logic            o_valid;
    logic [BITS-1:0] o_result;

    int vectors;
    int miscompares;
    int valid_cnt;

    bit_count_unit #(.BITS(BITS), .CHUNK(CHUNK)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_mode   (i_mode),
        .i_argA   (i_argA),
        .i_argB   (i_argB),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_result (o_result)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Count o_valid pulses away from the active edge.
    always @(negedge i_clk) begin
        if (o_valid === 1'b1) valid_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Word-level reference: counts over the whole 2*BITS operand.
    function automatic int model(input logic [WW-1:0] w, input logic [1:0] m);
        int n;
        int i;
        n = 0;
        case (m)
            2'b00: for (i = 0; i < WW; i++) n += (w[i] == 1'b0) ? 1 : 0;
            2'b01: for (i = 0; i < WW; i++) n += (w[i] == 1'b1) ? 1 : 0;
            2'b10: begin
                i = WW - 1;
                while (i >= 0 && w[i] == 1'b0) begin n++; i--; end
            end
            default: begin
                i = 0;
                while (i < WW && w[i] == 1'b0) begin n++; i++; end
            end
        endcase
        return n;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One complete count with timing checks; operands are scrambled after the start edge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                          input int exp, input string tag);
        int v0;
        v0 = valid_cnt;
        i_argA  = a;
        i_argB  = b;
        i_mode  = m;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_argA  = 8'($urandom);
        i_argB  = 8'($urandom);
        i_mode  = 2'($urandom);
        check({tag, "_busy_first"}, 32'(o_busy), 32'd1);
        check({tag, "_valid_first"}, 32'(o_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check({tag, "_busy_run"}, 32'(o_busy), 32'd1);
        end
        tick();
        check({tag, "_valid"}, 32'(o_valid), 32'd1);
        check({tag, "_busy_done"}, 32'(o_busy), 32'd0);
        check({tag, "_result"}, 32'(o_result), 32'(exp));
        tick();
        check({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
        check({tag, "_hold"}, 32'(o_result), 32'(exp));
        check({tag, "_pulses"}, 32'(valid_cnt - v0), 32'd1);
    endtask

    initial begin
        int v0;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] m;
        vectors     = 0;
        miscompares = 0;
        valid_cnt   = 0;
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_mode  = 2'b00;
        i_argA  = '0;
        i_argB  = '0;
        tick();
        tick();
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_result", 32'(o_result), 32'd0);
        i_rst = 1'b0;
        tick();

        // Directed vectors.
        run_op(8'h00, 8'h00, 2'b00, 16, "zeros_all");
        run_op(8'hF0, 8'h0F, 2'b01, 8, "ones_f00f");
        run_op(8'h01, 8'h80, 2'b10, 7, "lz_0180");
        run_op(8'h01, 8'h80, 2'b11, 7, "tz_0180");
        run_op(8'h00, 8'h01, 2'b11, 0, "tz_lsb");
        run_op(8'h00, 8'h00, 2'b10, 16, "lz_allzero");
        run_op(8'h00, 8'h00, 2'b11, 16, "tz_allzero");
        run_op(8'h80, 8'h00, 2'b10, 0, "lz_msb");

        // Start during RUN is ignored.
        v0 = valid_cnt;
        i_argA = 8'h01; i_argB = 8'h80; i_mode = 2'b10; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        i_argA = 8'hFF; i_argB = 8'hFF; i_mode = 2'b01; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("ign_busy", 32'(o_busy), 32'd1);
        tick();
        tick();
        check("ign_valid", 32'(o_valid), 32'd1);
        check("ign_result", 32'(o_result), 32'd7);
        repeat (8) tick();
        check("ign_pulses", 32'(valid_cnt - v0), 32'd1);

        // Reset in the second RUN cycle aborts the count.
        i_argA = 8'hF0; i_argB = 8'h0F; i_mode = 2'b01; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        v0 = valid_cnt;
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_valid", 32'(o_valid), 32'd0);
        check("abort_result", 32'(o_result), 32'd0);
        repeat (10) tick();
        check("abort_no_valid", 32'(valid_cnt - v0), 32'd0);

        // Back-to-back with i_start held high.
        i_mode = 2'b01; i_argA = 8'hFF; i_argB = 8'hFF; i_start = 1'b1;
        tick();
        i_argA = 8'h00; i_argB = 8'h01;
        repeat (4) tick();
        check("b2b_valid1", 32'(o_valid), 32'd1);
        check("b2b_result1", 32'(o_result), 32'd16);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("b2b_gap", 32'(o_valid), 32'd0);
        end
        tick();
        check("b2b_valid2", 32'(o_valid), 32'd1);
        check("b2b_result2", 32'(o_result), 32'd1);
        i_start = 1'b0;
        tick();
        tick();

        // Random counts against the word-level model.
        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            m = 2'($urandom_range(3, 0));
            if (n % 5 == 0) a = 8'h00;
            if (n % 7 == 0) b = 8'h00;
            run_op(a, b, m, model({a, b}, m), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
